pipe_hazard_ctrl: RTL and testbench

//  Central stall/flush sequencer for the 5-stage MIPS pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB regs).

---
 rtl/pipe_hazard_ctrl_pkg.sv | 32 +++
 rtl/pipe_hazard_ctrl_if.sv | 39 +++
 rtl/pipe_hazard_ctrl_hazard_detect.sv | 16 +
 rtl/pipe_hazard_ctrl.sv | 81 ++++++++
 tb/tb_pipe_hazard_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard sequencer.
// Each control word says how every pipeline register and the PC behave for one cycle.
package pipe_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    MWAIT = 2'd1,
    HALT  = 2'd2
  } state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic ifid_flush;
    logic idex_en;
    logic idex_flush;
    logic exmem_en;
    logic memwb_en;
    logic memwb_flush;
  } ctrl_t;

  // A flushed register still loads: it captures a bubble instead of upstream data.
  localparam ctrl_t CTRL_IDLE      = ctrl_t'(8'b0000_0000);
  localparam ctrl_t CTRL_MEM_STALL = ctrl_t'(8'b0000_0011);
  localparam ctrl_t CTRL_LOAD_USE  = ctrl_t'(8'b0001_1110);
  localparam ctrl_t CTRL_BRANCH    = ctrl_t'(8'b1111_1110);
  localparam ctrl_t CTRL_JUMP      = ctrl_t'(8'b1111_0110);
  localparam ctrl_t CTRL_FLOW      = ctrl_t'(8'b1101_0110);

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Datapath-facing signal bundle of the hazard sequencer.
// The datapath is the master (drives pipeline status); the sequencer is the slave.
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 32
);

  logic [4:0]       ifid_rs;
  logic [4:0]       ifid_rt;
  logic             idex_memrd;
  logic [4:0]       idex_rt;
  logic             jump_id;
  logic             branch_ex;
  logic             exmem_memacc;
  logic             dmem_ready;

  logic             pc_en;
  logic             ifid_en;
  logic             ifid_flush;
  logic             idex_en;
  logic             idex_flush;
  logic             exmem_en;
  logic             memwb_en;
  logic             memwb_flush;
  logic             halted;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output ifid_rs, ifid_rt, idex_memrd, idex_rt, jump_id, branch_ex, exmem_memacc, dmem_ready,
    input  pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en, memwb_flush,
    input  halted, stall_cnt
  );

  modport slave (
    input  ifid_rs, ifid_rt, idex_memrd, idex_rt, jump_id, branch_ex, exmem_memacc, dmem_ready,
    output pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en, memwb_flush,
    output halted, stall_cnt
  );

endinterface

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Load-use detector: the load in ID/EX writes a register the IF/ID instruction reads.
// Register zero is never a real dependency since it always reads as zero.
module hazard_detect
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic [4:0] ifid_rs_i,
  input  logic [4:0] ifid_rt_i,
  input  logic       idex_memrd_i,
  input  logic [4:0] idex_rt_i,
  output logic       lu_o
);

  assign lu_o = idex_memrd_i && (idex_rt_i != REG_ZERO) &&
                ((idex_rt_i == ifid_rs_i) || (idex_rt_i == ifid_rt_i));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: memory-wait freeze with timeout halt,
// load-use bubble, branch/jump squash, plus a stall-cycle performance counter.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic              clk,
  input  logic              reset,
  pipe_hazard_ctrl_if.slave hz
);

  localparam int                WAIT_W     = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0]  stall_q, stall_d;
  logic              lu;
  logic              mbusy;
  ctrl_t             ctrl;

  hazard_detect u_hazard_detect (
    .ifid_rs_i    (hz.ifid_rs),
    .ifid_rt_i    (hz.ifid_rt),
    .idex_memrd_i (hz.idex_memrd),
    .idex_rt_i    (hz.idex_rt),
    .lu_o         (lu)
  );

  assign mbusy = hz.exmem_memacc & ~hz.dmem_ready;

  // RUN and MWAIT decode identically; MWAIT only differs in carrying a live wait count.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    ctrl    = CTRL_IDLE;
    if (state_q != HALT) begin
      if (mbusy) begin
        ctrl    = CTRL_MEM_STALL;
        wait_d  = wait_q + WAIT_W'(1);
        state_d = (wait_d == WAIT_LIMIT) ? HALT : MWAIT;
      end else begin
        wait_d  = '0;
        state_d = RUN;
        if (lu)                ctrl = CTRL_LOAD_USE;
        else if (hz.branch_ex) ctrl = CTRL_BRANCH;
        else if (hz.jump_id)   ctrl = CTRL_JUMP;
        else                   ctrl = CTRL_FLOW;
      end
    end
    if (reset) ctrl = CTRL_IDLE;
  end

  assign stall_d = stall_q + {{(CNT_W-1){1'b0}}, ~ctrl.pc_en};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      wait_q  <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      stall_q <= stall_d;
    end
  end

  assign hz.pc_en       = ctrl.pc_en;
  assign hz.ifid_en     = ctrl.ifid_en;
  assign hz.ifid_flush  = ctrl.ifid_flush;
  assign hz.idex_en     = ctrl.idex_en;
  assign hz.idex_flush  = ctrl.idex_flush;
  assign hz.exmem_en    = ctrl.exmem_en;
  assign hz.memwb_en    = ctrl.memwb_en;
  assign hz.memwb_flush = ctrl.memwb_flush;
  assign hz.halted      = (state_q == HALT);
  assign hz.stall_cnt   = stall_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed hazard scenarios plus random traffic
// compared against a behavioural model of the stall/flush rules.
module tb_pipe_hazard_ctrl;

  localparam int MEM_TIMEOUT = 16;
  localparam int CNT_W       = 32;

  // Expected control words, bit order {pc, ifid_en, ifid_fl, idex_en, idex_fl, exmem, memwb_en, memwb_fl}
  localparam logic [7:0] EXP_OFF    = 8'b0000_0000;
  localparam logic [7:0] EXP_MEM    = 8'b0000_0011;
  localparam logic [7:0] EXP_LU     = 8'b0001_1110;
  localparam logic [7:0] EXP_BRANCH = 8'b1111_1110;
  localparam logic [7:0] EXP_JUMP   = 8'b1111_0110;
  localparam logic [7:0] EXP_FLOW   = 8'b1101_0110;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.CNT_W(CNT_W)) hz ();

  pipe_hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz)
  );

  int total = 0;
  int bad   = 0;

  bit               mHalt;
  int               mWait;
  logic [CNT_W-1:0] mStall;

  function automatic logic [7:0] dutCtrl();
    return {hz.pc_en, hz.ifid_en, hz.ifid_flush, hz.idex_en,
            hz.idex_flush, hz.exmem_en, hz.memwb_en, hz.memwb_flush};
  endfunction

  function automatic bit modelBusy();
    return hz.exmem_memacc && !hz.dmem_ready;
  endfunction

  // Control word the rules require for the current inputs and model status.
  function automatic logic [7:0] modelCtrl();
    bit loadUse;
    loadUse = hz.idex_memrd && (hz.idex_rt != 5'd0) &&
              (hz.idex_rt == hz.ifid_rs || hz.idex_rt == hz.ifid_rt);
    if (reset || mHalt) return EXP_OFF;
    if (modelBusy())    return EXP_MEM;
    if (loadUse)        return EXP_LU;
    if (hz.branch_ex)   return EXP_BRANCH;
    if (hz.jump_id)     return EXP_JUMP;
    return EXP_FLOW;
  endfunction

  // Commits one clock of model history, then moves to just after the next rising edge.
  task automatic finishCycle(input logic [7:0] expCtrl);
    if (!mHalt) begin
      if (modelBusy()) begin
        mWait++;
        if (mWait >= MEM_TIMEOUT) mHalt = 1'b1;
      end else begin
        mWait = 0;
      end
    end
    if (!expCtrl[7]) mStall = mStall + 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [4:0] rs, input logic [4:0] rt, input logic memrd,
                               input logic [4:0] idrt, input logic jump, input logic branch,
                               input logic memacc, input logic ready);
    hz.ifid_rs      = rs;
    hz.ifid_rt      = rt;
    hz.idex_memrd   = memrd;
    hz.idex_rt      = idrt;
    hz.jump_id      = jump;
    hz.branch_ex    = branch;
    hz.exmem_memacc = memacc;
    hz.dmem_ready   = ready;
    @(negedge clk);
  endtask

  task automatic resetDut();
    reset = 1'b1;
    hz.ifid_rs = 5'd0; hz.ifid_rt = 5'd0; hz.idex_memrd = 1'b0; hz.idex_rt = 5'd0;
    hz.jump_id = 1'b0; hz.branch_ex = 1'b0; hz.exmem_memacc = 1'b0; hz.dmem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset  = 1'b0;
    mHalt  = 1'b0;
    mWait  = 0;
    mStall = '0;
  endtask

  task automatic test_reset();
    logic [7:0] got;
    reset = 1'b1;
    applyStimulus(5'd2, 5'd3, 1'b1, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1);
    got = dutCtrl();
    total++;
    if (got !== EXP_OFF) begin
      bad++;
      $display("[TB] FAIL reset_outputs got=%b want=%b", got, EXP_OFF);
    end
    total++;
    if (hz.halted !== 1'b0 || hz.stall_cnt !== '0) begin
      bad++;
      $display("[TB] FAIL reset_state halted=%b stall=%0d want halted=0 stall=0", hz.halted, hz.stall_cnt);
    end
    resetDut();
  endtask

  task automatic test_load_use();
    logic [7:0] exp;
    resetDut();
    applyStimulus(5'd2, 5'd4, 1'b1, 5'd2, 1'b0, 1'b0, 1'b0, 1'b1);
    exp = modelCtrl();
    total++;
    if (dutCtrl() !== EXP_LU || exp !== EXP_LU) begin
      bad++;
      $display("[TB] FAIL load_use got=%b want=%b", dutCtrl(), EXP_LU);
    end
    finishCycle(exp);
    applyStimulus(5'd5, 5'd6, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1);
    exp = modelCtrl();
    total++;
    if (dutCtrl() !== EXP_FLOW) begin
      bad++;
      $display("[TB] FAIL load_use_after got=%b want=%b", dutCtrl(), EXP_FLOW);
    end
    total++;
    if (hz.stall_cnt !== 32'd1) begin
      bad++;
      $display("[TB] FAIL load_use_stallcnt got=%0d want=1", hz.stall_cnt);
    end
    finishCycle(exp);
  endtask

  task automatic test_reg_zero();
    logic [7:0] exp;
    resetDut();
    applyStimulus(5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    exp = modelCtrl();
    total++;
    if (dutCtrl() !== EXP_FLOW) begin
      bad++;
      $display("[TB] FAIL reg_zero got=%b want=%b", dutCtrl(), EXP_FLOW);
    end
    finishCycle(exp);
    applyStimulus(5'd9, 5'd1, 1'b1, 5'd1, 1'b0, 1'b0, 1'b0, 1'b1);
    exp = modelCtrl();
    total++;
    if (dutCtrl() !== EXP_LU) begin
      bad++;
      $display("[TB] FAIL load_use_rt got=%b want=%b", dutCtrl(), EXP_LU);
    end
    finishCycle(exp);
  endtask

  task automatic test_mem_wait();
    logic [7:0] exp;
    resetDut();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      exp = modelCtrl();
      total++;
      if (dutCtrl() !== EXP_MEM) begin
        bad++;
        $display("[TB] FAIL mem_wait_%0d got=%b want=%b", i, dutCtrl(), EXP_MEM);
      end
      finishCycle(exp);
    end
    applyStimulus(5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    exp = modelCtrl();
    total++;
    if (dutCtrl() !== EXP_FLOW || hz.halted !== 1'b0) begin
      bad++;
      $display("[TB] FAIL mem_release got=%b halted=%b want=%b halted=0", dutCtrl(), hz.halted, EXP_FLOW);
    end
    total++;
    if (hz.stall_cnt !== 32'd3) begin
      bad++;
      $display("[TB] FAIL mem_wait_stallcnt got=%0d want=3", hz.stall_cnt);
    end
    finishCycle(exp);
  endtask

  task automatic test_branch_jump();
    logic [7:0] exp;
    resetDut();
    applyStimulus(5'd1, 5'd2, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1);
    exp = modelCtrl();
    total++;
    if (dutCtrl() !== EXP_BRANCH) begin
      bad++;
      $display("[TB] FAIL branch_and_jump got=%b want=%b", dutCtrl(), EXP_BRANCH);
    end
    finishCycle(exp);
    applyStimulus(5'd1, 5'd2, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    exp = modelCtrl();
    total++;
    if (dutCtrl() !== EXP_JUMP) begin
      bad++;
      $display("[TB] FAIL jump_only got=%b want=%b", dutCtrl(), EXP_JUMP);
    end
    finishCycle(exp);
  endtask

  task automatic test_timeout();
    logic [7:0] exp;
    resetDut();
    for (int i = 0; i < MEM_TIMEOUT; i++) begin
      applyStimulus(5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      exp = modelCtrl();
      total++;
      if (dutCtrl() !== exp || hz.halted !== 1'b0) begin
        bad++;
        $display("[TB] FAIL timeout_wait_%0d got=%b halted=%b want=%b halted=0", i, dutCtrl(), hz.halted, exp);
      end
      finishCycle(exp);
    end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(5'($urandom), 5'($urandom), 1'($urandom), 5'($urandom),
                    1'($urandom), 1'($urandom), 1'($urandom), 1'b1);
      exp = modelCtrl();
      total++;
      if (dutCtrl() !== EXP_OFF || hz.halted !== 1'b1) begin
        bad++;
        $display("[TB] FAIL halt_%0d got=%b halted=%b want=%b halted=1", i, dutCtrl(), hz.halted, EXP_OFF);
      end
      total++;
      if (hz.stall_cnt !== CNT_W'(MEM_TIMEOUT + i)) begin
        bad++;
        $display("[TB] FAIL halt_stallcnt_%0d got=%0d want=%0d", i, hz.stall_cnt, MEM_TIMEOUT + i);
      end
      finishCycle(exp);
    end
    reset = 1'b1;
    #2;
    total++;
    if (hz.halted !== 1'b0 || hz.stall_cnt !== '0 || dutCtrl() !== EXP_OFF) begin
      bad++;
      $display("[TB] FAIL reset_mid_halt halted=%b stall=%0d ctrl=%b want 0/0/%b",
               hz.halted, hz.stall_cnt, dutCtrl(), EXP_OFF);
    end
    resetDut();
    applyStimulus(5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    exp = modelCtrl();
    total++;
    if (dutCtrl() !== EXP_FLOW) begin
      bad++;
      $display("[TB] FAIL run_after_reset got=%b want=%b", dutCtrl(), EXP_FLOW);
    end
    finishCycle(exp);
  endtask

  task automatic test_mbusy_lu();
    logic [7:0] exp;
    resetDut();
    applyStimulus(5'd3, 5'd4, 1'b1, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0);
    exp = modelCtrl();
    total++;
    if (dutCtrl() !== EXP_MEM) begin
      bad++;
      $display("[TB] FAIL mbusy_over_lu got=%b want=%b", dutCtrl(), EXP_MEM);
    end
    finishCycle(exp);
    applyStimulus(5'd3, 5'd4, 1'b1, 5'd3, 1'b0, 1'b1, 1'b1, 1'b1);
    exp = modelCtrl();
    total++;
    if (dutCtrl() !== EXP_LU) begin
      bad++;
      $display("[TB] FAIL lu_on_release got=%b want=%b", dutCtrl(), EXP_LU);
    end
    finishCycle(exp);
    applyStimulus(5'd5, 5'd6, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1);
    exp = modelCtrl();
    total++;
    if (dutCtrl() !== EXP_FLOW || hz.stall_cnt !== 32'd2) begin
      bad++;
      $display("[TB] FAIL mbusy_lu_after got=%b stall=%0d want=%b stall=2", dutCtrl(), hz.stall_cnt, EXP_FLOW);
    end
    finishCycle(exp);
  endtask

  task automatic test_random();
    logic [7:0] exp;
    resetDut();
    for (int i = 0; i < 400; i++) begin
      if (mHalt && ($urandom_range(0, 3) == 0)) resetDut();
      applyStimulus(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                    1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) < 4));
      exp = modelCtrl();
      total++;
      if (dutCtrl() !== exp || hz.halted !== mHalt || hz.stall_cnt !== mStall) begin
        bad++;
        $display("[TB] FAIL random_%0d ctrl=%b halted=%b stall=%0d want ctrl=%b halted=%b stall=%0d",
                 i, dutCtrl(), hz.halted, hz.stall_cnt, exp, mHalt, mStall);
      end
      finishCycle(exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    mHalt = 1'b0;
    mWait = 0;
    mStall = '0;
    test_reset();
    test_load_use();
    test_reg_zero();
    test_mem_wait();
    test_branch_jump();
    test_timeout();
    test_mbusy_lu();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
